cnn_layer_sequencer: RTL and testbench



---
 rtl/cnn_layer_sequencer.sv | 129 ++++++++++++
 tb/tb_cnn_layer_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_sequencer.sv
// Layer sequencer: time-multiplexes one convolution engine across the CNN layer chain.
// Optional watchdog on the engine wait is enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_layer_sequencer #(
    parameter int                    NUM_LAYERS          = 5,
    parameter int                    LAYER_IDX_W         = 3,
    parameter int                    MAX_IMAGE_SIZE_LOG2 = 9,
    parameter logic [NUM_LAYERS-1:0] STRIDE2_MASK        = 5'b00010,
    parameter int                    TIMEOUT_CYCLES      = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           size_detection_done,
    input  logic [MAX_IMAGE_SIZE_LOG2:0]   image_size,
    input  logic                           abort,
    output logic                           eng_start,
    output logic [LAYER_IDX_W-1:0]         eng_layer,
    output logic [MAX_IMAGE_SIZE_LOG2:0]   eng_in_size,
    output logic [MAX_IMAGE_SIZE_LOG2:0]   eng_out_size,
    output logic                           eng_stride2,
    output logic                           eng_src_buf,
    input  logic                           eng_done,
    output logic                           features_valid,
    output logic                           final_buf,
    input  logic                           features_ack,
    output logic                           busy,
    output logic                           error
);
    localparam int SW     = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int NL_EXT = 1 << LAYER_IDX_W;
    localparam logic [SW-1:0]          MAX_SIZE   = SW'(1) << MAX_IMAGE_SIZE_LOG2;
    localparam logic [NL_EXT-1:0]      MASK_EXT   = NL_EXT'(STRIDE2_MASK);
    localparam logic [LAYER_IDX_W-1:0] LAST_LAYER = LAYER_IDX_W'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t                   state, state_nx;
    logic                     size_ok;
    logic                     last_layer;
    logic                     timeout;
    logic [LAYER_IDX_W-1:0]   next_layer;
    logic                     next_stride2;

    // Ceiling halving for stride-2 layers; never yields 0 for a nonzero input.
    function automatic logic [SW-1:0] out_size_f(input logic [SW-1:0] s, input logic st);
        logic [SW:0] sum;
        sum = {1'b0, s} + 1'b1;
        return st ? sum[SW:1] : s;
    endfunction

    assign size_ok      = (image_size != '0) && (image_size <= MAX_SIZE);
    assign last_layer   = (eng_layer == LAST_LAYER);
    assign next_layer   = eng_layer + 1'b1;
    assign next_stride2 = MASK_EXT[next_layer];

`ifdef CNN_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already elapsed in this layer.
    always_ff @(posedge clk) begin
        if (rst)                wait_cnt <= '0;
        else if (state == ISSUE) wait_cnt <= '0;
        else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_unused;
    assign timeout_unused = |32'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (size_detection_done) state_nx = size_ok ? ISSUE : ERR;
            ISSUE:   state_nx = WAIT;
            WAIT: begin
                if (eng_done)     state_nx = last_layer ? DONE : ISSUE;
                else if (timeout) state_nx = ERR;
            end
            DONE:    if (features_ack) state_nx = IDLE;
            ERR:     state_nx = ERR;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // Engine command registers: loaded on entry to ISSUE, held through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_layer    <= '0;
            eng_in_size  <= '0;
            eng_out_size <= '0;
            eng_stride2  <= 1'b0;
            eng_src_buf  <= 1'b0;
            final_buf    <= 1'b0;
        end else if (!abort) begin
            if (state == IDLE && size_detection_done && size_ok) begin
                eng_layer    <= '0;
                eng_in_size  <= image_size;
                eng_stride2  <= MASK_EXT[0];
                eng_out_size <= out_size_f(image_size, MASK_EXT[0]);
                eng_src_buf  <= 1'b0;
            end else if (state == WAIT && eng_done) begin
                if (last_layer) begin
                    final_buf <= ~eng_src_buf;
                end else begin
                    eng_layer    <= next_layer;
                    eng_in_size  <= eng_out_size;
                    eng_stride2  <= next_stride2;
                    eng_out_size <= out_size_f(eng_out_size, next_stride2);
                    eng_src_buf  <= ~eng_src_buf;
                end
            end
        end
    end

    assign eng_start      = (state == ISSUE);
    assign features_valid = (state == DONE);
    assign busy           = (state != IDLE);
    assign error          = (state == ERR);

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: expected engine commands are queued per run
// and checked against each eng_start as it appears.
module tb_cnn_layer_sequencer;
    localparam int         NL   = 5;
    localparam logic [4:0] MASK = 5'b00010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       size_detection_done = 1'b0;
    logic [9:0] image_size = '0;
    logic       abort = 1'b0;
    logic       eng_start;
    logic [2:0] eng_layer;
    logic [9:0] eng_in_size, eng_out_size;
    logic       eng_stride2, eng_src_buf;
    logic       eng_done = 1'b0;
    logic       features_valid, final_buf;
    logic       features_ack = 1'b0;
    logic       busy, error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int layer;
        int in_sz;
        int out_sz;
        int st;
        int src;
    } issue_t;

    issue_t q[$];
    int     exp_final;

    cnn_layer_sequencer #(
        .NUM_LAYERS(NL), .LAYER_IDX_W(3), .MAX_IMAGE_SIZE_LOG2(9),
        .STRIDE2_MASK(MASK), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .size_detection_done(size_detection_done), .image_size(image_size),
        .abort(abort),
        .eng_start(eng_start), .eng_layer(eng_layer),
        .eng_in_size(eng_in_size), .eng_out_size(eng_out_size),
        .eng_stride2(eng_stride2), .eng_src_buf(eng_src_buf),
        .eng_done(eng_done),
        .features_valid(features_valid), .final_buf(final_buf),
        .features_ack(features_ack),
        .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int size);
        int s;
        s = size;
        for (int l = 0; l < NL; l++) begin
            issue_t e;
            e.layer  = l;
            e.in_sz  = s;
            e.st     = MASK[l];
            e.out_sz = MASK[l] ? (s + 1) / 2 : s;
            e.src    = l % 2;
            q.push_back(e);
            s = e.out_sz;
        end
        exp_final = (NL % 2 == 1) ? 1 : 0;
    endtask

    task automatic wait_start(input int budget, output int lat);
        lat = -1;
        for (int i = 0; i <= budget; i++) begin
            if (eng_start === 1'b1) begin
                lat = i;
                break;
            end
            tick();
        end
    endtask

    task automatic run_image(input int size, input int dly, input int abort_layer, input bit stray);
        int lat;
        int starts;
        issue_t e;
        push_run(size);
        image_size = 10'(size);
        size_detection_done = 1'b1;
        tick();
        size_detection_done = 1'b0;
        for (int l = 0; l < NL; l++) begin
            wait_start(20, lat);
            chk("start_latency", lat, 0);
            if (lat < 0 || q.size() == 0) begin
                q.delete();
                return;
            end
            e = q.pop_front();
            chk("eng_layer", 32'(eng_layer), e.layer);
            chk("eng_in_size", 32'(eng_in_size), e.in_sz);
            chk("eng_out_size", 32'(eng_out_size), e.out_sz);
            chk("eng_stride2", 32'(eng_stride2), e.st);
            chk("eng_src_buf", 32'(eng_src_buf), e.src);
            if (stray && l == 0) begin
                eng_done = 1'b1;
                tick();
                eng_done = 1'b0;
                chk("stray_done_issue_layer", 32'(eng_layer), 0);
                chk("stray_done_issue_busy", 32'(busy), 1);
                image_size = 10'd99;
                size_detection_done = 1'b1;
                tick();
                size_detection_done = 1'b0;
                chk("stray_sdd_in_size", 32'(eng_in_size), e.in_sz);
                chk("stray_sdd_layer", 32'(eng_layer), 0);
            end else begin
                tick();
            end
            chk("start_single_cycle", 32'(eng_start), 0);
            repeat (dly - 1) tick();
            eng_done = 1'b1;
            if (l == abort_layer) abort = 1'b1;
            tick();
            eng_done = 1'b0;
            abort = 1'b0;
            if (l == abort_layer) begin
                chk("abort_busy", 32'(busy), 0);
                chk("abort_start", 32'(eng_start), 0);
                q.delete();
                starts = 0;
                repeat (10) begin
                    if (eng_start === 1'b1) starts++;
                    tick();
                end
                chk("abort_no_more_starts", starts, 0);
                return;
            end
        end
        chk("features_valid_rise", 32'(features_valid), 1);
        chk("final_buf", 32'(final_buf), exp_final);
        tick();
        tick();
        chk("features_valid_hold", 32'(features_valid), 1);
        features_ack = 1'b1;
        tick();
        features_ack = 1'b0;
        chk("features_valid_drop", 32'(features_valid), 0);
        chk("idle_after_ack", 32'(busy), 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_eng_start", 32'(eng_start), 0);
        chk("rst_eng_layer", 32'(eng_layer), 0);
        chk("rst_eng_in_size", 32'(eng_in_size), 0);
        chk("rst_eng_out_size", 32'(eng_out_size), 0);
        chk("rst_eng_stride2", 32'(eng_stride2), 0);
        chk("rst_eng_src_buf", 32'(eng_src_buf), 0);
        chk("rst_features_valid", 32'(features_valid), 0);
        chk("rst_final_buf", 32'(final_buf), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_error", 32'(error), 0);
        rst = 1'b0;
        tick();

        run_image(224, 3, -1, 1'b0);
        run_image(7, 3, -1, 1'b0);
        run_image(1, 2, -1, 1'b0);
        run_image(512, 1, -1, 1'b0);

        // Illegal sizes
        image_size = 10'd0;
        size_detection_done = 1'b1;
        tick();
        size_detection_done = 1'b0;
        chk("size0_error", 32'(error), 1);
        chk("size0_no_start", 32'(eng_start), 0);
        chk("size0_busy", 32'(busy), 1);
        image_size = 10'd224;
        size_detection_done = 1'b1;
        tick();
        size_detection_done = 1'b0;
        chk("err_ignores_sdd_start", 32'(eng_start), 0);
        chk("err_ignores_sdd_error", 32'(error), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_clears_error", 32'(error), 0);
        chk("abort_err_busy", 32'(busy), 0);
        image_size = 10'd513;
        size_detection_done = 1'b1;
        tick();
        size_detection_done = 1'b0;
        chk("size513_error", 32'(error), 1);
        chk("size513_no_start", 32'(eng_start), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_clears_error", 32'(error), 0);
        chk("rst_err_busy", 32'(busy), 0);

        // Stray eng_done in IDLE
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("stray_done_idle_busy", 32'(busy), 0);
        chk("stray_done_idle_start", 32'(eng_start), 0);
        chk("stray_done_idle_valid", 32'(features_valid), 0);

        run_image(224, 3, -1, 1'b1);
        run_image(224, 3, 2, 1'b0);
        run_image(100, 2, -1, 1'b0);

        // Engine never completes
        image_size = 10'd224;
        size_detection_done = 1'b1;
        tick();
        size_detection_done = 1'b0;
        wait_start(20, lat);
        chk("wd_start_latency", lat, 0);
`ifdef CNN_SEQ_TIMEOUT_EN
        repeat (16) tick();
        chk("wd_before_limit", 32'(error), 0);
        tick();
        chk("wd_error", 32'(error), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("wd_abort_clears", 32'(error), 0);
        image_size = 10'd224;
        size_detection_done = 1'b1;
        tick();
        size_detection_done = 1'b0;
        wait_start(20, lat);
        chk("wd2_start_latency", lat, 0);
        repeat (16) tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("wd_done_wins_start", 32'(eng_start), 1);
        chk("wd_done_wins_layer", 32'(eng_layer), 1);
        chk("wd_done_wins_error", 32'(error), 0);
`else
        repeat (40) tick();
        chk("no_wd_error", 32'(error), 0);
        chk("no_wd_busy", 32'(busy), 1);
        chk("no_wd_start", 32'(eng_start), 0);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("final_abort_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
